// File: rtl/feeder_pkg.sv
// Shared types and constants for the convolution window feeder.
package feeder_pkg;

    localparam int unsigned CFG_AW     = 16;
    localparam int unsigned MAX_STRIDE = 3;
    localparam int unsigned MAX_PAD    = 3;
    localparam int unsigned STRIDE_W   = $clog2(MAX_STRIDE + 1);
    localparam int unsigned PAD_W      = $clog2(MAX_PAD + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } feeder_state_t;

    typedef struct packed {
        logic [CFG_AW-1:0]   in_rows;
        logic [CFG_AW-1:0]   in_cols;
        logic [CFG_AW-1:0]   chans;
        logic [CFG_AW-1:0]   batch;
        logic [CFG_AW-1:0]   k_dim;
        logic [CFG_AW-1:0]   o_rows;
        logic [CFG_AW-1:0]   o_cols;
        logic [STRIDE_W-1:0] stride;
        logic [PAD_W-1:0]    pad;
    } feeder_cfg_t;

endpackage

// File: rtl/window_addr_gen.sv
// Walks the b/oy/ox/ky/kx/c loop nest and maps each window position to a RAM
// address, flagging positions that fall in the zero-padded border.
module window_addr_gen
    import feeder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CFG_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  adv,
    input  feeder_cfg_t           cfg,
    output logic [ADDR_WIDTH-1:0] addr_c,
    output logic                  pad_zero_c,
    output logic                  last_c
);

    localparam int unsigned SW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] b_q, oy_q, ox_q, ky_q, kx_q, c_q;
    logic                  c_w, kx_w, ky_w, ox_w, oy_w, b_w;
    logic [ADDR_WIDTH-1:0] stride_c;
    logic [SW-1:0]         iy_c, ix_c;

    // Wrap flags, signed input coordinates and the flattened address
    always_comb begin
        c_w  = (c_q  == ADDR_WIDTH'(cfg.chans)  - ONE);
        kx_w = (kx_q == ADDR_WIDTH'(cfg.k_dim)  - ONE);
        ky_w = (ky_q == ADDR_WIDTH'(cfg.k_dim)  - ONE);
        ox_w = (ox_q == ADDR_WIDTH'(cfg.o_cols) - ONE);
        oy_w = (oy_q == ADDR_WIDTH'(cfg.o_rows) - ONE);
        b_w  = (b_q  == ADDR_WIDTH'(cfg.batch)  - ONE);
        last_c = c_w && kx_w && ky_w && ox_w && oy_w && b_w;

        stride_c = (cfg.stride == '0) ? ONE : ADDR_WIDTH'(cfg.stride);
        iy_c = SW'(oy_q) * SW'(stride_c) + SW'(ky_q) - SW'(cfg.pad);
        ix_c = SW'(ox_q) * SW'(stride_c) + SW'(kx_q) - SW'(cfg.pad);

        // MSB is the sign of the (ADDR_WIDTH+1)-bit coordinate
        pad_zero_c = iy_c[SW-1] || ix_c[SW-1]
                  || (iy_c >= SW'(cfg.in_rows))
                  || (ix_c >= SW'(cfg.in_cols));

        addr_c = ((b_q * ADDR_WIDTH'(cfg.in_rows) + ADDR_WIDTH'(iy_c))
                  * ADDR_WIDTH'(cfg.in_cols) + ADDR_WIDTH'(ix_c))
                 * ADDR_WIDTH'(cfg.chans) + c_q;
    end

    // Nested counters, channel innermost; each carries into the next outer one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_q  <= '0;
            oy_q <= '0;
            ox_q <= '0;
            ky_q <= '0;
            kx_q <= '0;
            c_q  <= '0;
        end else if (clear) begin
            b_q  <= '0;
            oy_q <= '0;
            ox_q <= '0;
            ky_q <= '0;
            kx_q <= '0;
            c_q  <= '0;
        end else if (adv) begin
            c_q <= c_w ? '0 : c_q + ONE;
            if (c_w)
                kx_q <= kx_w ? '0 : kx_q + ONE;
            if (c_w && kx_w)
                ky_q <= ky_w ? '0 : ky_q + ONE;
            if (c_w && kx_w && ky_w)
                ox_q <= ox_w ? '0 : ox_q + ONE;
            if (c_w && kx_w && ky_w && ox_w)
                oy_q <= oy_w ? '0 : oy_q + ONE;
            if (c_w && kx_w && ky_w && ox_w && oy_w)
                b_q <= b_w ? '0 : b_q + ONE;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Buffers one batch of feature maps, then streams every KxK window (channel
// innermost, zero-padded) through a 2-entry output FIFO with valid/ready.
module conv_window_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = CFG_AW,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_in_rows,
    input  logic [ADDR_WIDTH-1:0] cfg_in_cols,
    input  logic [ADDR_WIDTH-1:0] cfg_chans,
    input  logic [ADDR_WIDTH-1:0] cfg_batch,
    input  logic [ADDR_WIDTH-1:0] cfg_k_dim,
    input  logic [ADDR_WIDTH-1:0] cfg_o_rows,
    input  logic [ADDR_WIDTH-1:0] cfg_o_cols,
    input  logic [STRIDE_W-1:0]   cfg_stride,
    input  logic [PAD_W-1:0]      cfg_pad,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  ram_full,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned RAM_AW = $clog2(DEPTH);

    feeder_state_t         state_q, state_d;
    feeder_cfg_t           cfg_q;
    logic [ADDR_WIDTH-1:0] n_in_q, wr_ptr_q;
    logic                  in_ready_q, ram_full_q, busy_q, gen_done_q;
    logic                  wr_en_c, wr_last_c, pop_c, room_c, issue_c, push_l_c;
    logic [1:0]            occ_c;
    logic [DATA_WIDTH-1:0] push_d_c;
    logic [ADDR_WIDTH-1:0] gen_addr_c;
    logic                  gen_pad_c, gen_last_c;
    logic                  rd_v_q, rd_pad_q, rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  head_v_q, head_l_q, tail_v_q, tail_l_q;
    logic [DATA_WIDTH-1:0] head_d_q, tail_d_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Handshakes and generator flow control
    always_comb begin
        wr_en_c   = in_valid && in_ready_q;
        wr_last_c = wr_en_c && (wr_ptr_q == n_in_q - ADDR_WIDTH'(1));
        pop_c     = head_v_q && out_ready;
        occ_c     = 2'(head_v_q) + 2'(tail_v_q) + 2'(rd_v_q);
        // FIFO slots plus the read in flight must leave room after this cycle's pop
        room_c    = (occ_c < 2'd2) || (pop_c && (occ_c == 2'd2));
        issue_c   = (state_q == STREAM) && !gen_done_q && room_c;
        push_d_c  = (rd_v_q && !rd_pad_q) ? rd_data_q : '0;
        push_l_c  = rd_v_q && rd_last_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (wr_last_c) state_d = STREAM;
            STREAM:  if (pop_c && head_l_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Status outputs track the next state so they align with state_q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            ram_full_q <= 1'b0;
        end else begin
            busy_q     <= (state_d != IDLE);
            in_ready_q <= (state_d == LOAD);
            ram_full_q <= (state_d == STREAM) || (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q    <= '0;
            n_in_q   <= '0;
            wr_ptr_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cfg_q <= '{in_rows: CFG_AW'(cfg_in_rows), in_cols: CFG_AW'(cfg_in_cols),
                       chans:   CFG_AW'(cfg_chans),   batch:   CFG_AW'(cfg_batch),
                       k_dim:   CFG_AW'(cfg_k_dim),   o_rows:  CFG_AW'(cfg_o_rows),
                       o_cols:  CFG_AW'(cfg_o_cols),  stride:  cfg_stride,
                       pad:     cfg_pad};
            n_in_q   <= ADDR_WIDTH'(cfg_in_rows * cfg_in_cols * cfg_chans * cfg_batch);
            wr_ptr_q <= '0;
        end else if (wr_en_c) begin
            wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
        end
    end

    window_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q != STREAM),
        .adv        (issue_c),
        .cfg        (cfg_q),
        .addr_c     (gen_addr_c),
        .pad_zero_c (gen_pad_c),
        .last_c     (gen_last_c)
    );

    // Read pipeline stage; padded bubbles skip the RAM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_done_q <= 1'b0;
            rd_v_q     <= 1'b0;
            rd_pad_q   <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            if (state_q != STREAM)          gen_done_q <= 1'b0;
            else if (issue_c && gen_last_c) gen_done_q <= 1'b1;
            rd_v_q    <= issue_c;
            rd_pad_q  <= gen_pad_c;
            rd_last_q <= gen_last_c;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c)
            mem[RAM_AW'(wr_ptr_q)] <= in_data;
        if (issue_c && !gen_pad_c)
            rd_data_q <= mem[RAM_AW'(gen_addr_c)];
    end

    // 2-entry shift FIFO; head entry drives the output port directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_v_q <= 1'b0;
            head_l_q <= 1'b0;
            head_d_q <= '0;
            tail_v_q <= 1'b0;
            tail_l_q <= 1'b0;
            tail_d_q <= '0;
        end else if (pop_c) begin
            if (tail_v_q) begin
                head_v_q <= 1'b1;
                head_l_q <= tail_l_q;
                head_d_q <= tail_d_q;
                tail_v_q <= rd_v_q;
                tail_l_q <= push_l_c;
                tail_d_q <= push_d_c;
            end else begin
                head_v_q <= rd_v_q;
                head_l_q <= push_l_c;
                head_d_q <= push_d_c;
            end
        end else if (rd_v_q) begin
            if (!head_v_q) begin
                head_v_q <= 1'b1;
                head_l_q <= push_l_c;
                head_d_q <= push_d_c;
            end else begin
                tail_v_q <= 1'b1;
                tail_l_q <= push_l_c;
                tail_d_q <= push_d_c;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign ram_full  = ram_full_q;
    assign busy      = busy_q;
    assign out_valid = head_v_q;
    assign out_data  = head_d_q;
    assign out_last  = head_l_q;

endmodule
